// File: rtl/ysyx_23060077_icache_assoc_pkg.sv
// Shared constants and FSM encoding for the set-associative instruction cache.
package ysyx_23060077_define;

    localparam int DEF_OFFSET_W = 4;
    localparam int DEF_INDEX_W  = 4;
    localparam int DEF_WAYS     = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HIT    = 2'd1,
        S_REFILL = 2'd2,
        S_RESP   = 2'd3
    } icache_state_e;

endpackage

// File: rtl/ysyx_23060077_icache_way.sv
// One cache way: valid bits, tag array and line data array with a combinational
// lookup port and a whole-line write port.
module ysyx_23060077_icache_way #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 24,
    parameter int WORDS   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        inval_all_i,
    input  logic [INDEX_W-1:0]          rd_index_i,
    input  logic [TAG_W-1:0]            rd_tag_i,
    output logic                        hit_o,
    output logic                        valid_o,
    output logic [WORDS-1:0][31:0]      rd_line_o,
    input  logic                        we_i,
    input  logic [INDEX_W-1:0]          wr_index_i,
    input  logic [TAG_W-1:0]            wr_tag_i,
    input  logic [WORDS-1:0][31:0]      wr_line_i
);

    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]          valid_q, valid_d;
    logic [TAG_W-1:0]         tag_mem  [SETS];
    logic [WORDS-1:0][31:0]   data_mem [SETS];

    always_comb begin
        valid_d = valid_q;
        if (inval_all_i) begin
            valid_d = '0;
        end else if (we_i) begin
            valid_d[wr_index_i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clock) begin
        if (we_i) begin
            tag_mem[wr_index_i]  <= wr_tag_i;
            data_mem[wr_index_i] <= wr_line_i;
        end
    end

    assign valid_o   = valid_q[rd_index_i];
    assign hit_o     = valid_q[rd_index_i] && (tag_mem[rd_index_i] == rd_tag_i);
    assign rd_line_o = data_mem[rd_index_i];

endmodule

// File: rtl/ysyx_23060077_icache_assoc.sv
// Set-associative instruction cache with burst refill, fence.i invalidation,
// lowest-invalid/round-robin replacement and hit/miss counters.
module ysyx_23060077_icache_assoc
    import ysyx_23060077_define::*;
#(
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int WAYS     = DEF_WAYS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_r_valid_i,
    input  logic [31:0] ifu_r_addr_i,
    output logic        ifu_r_ready_o,
    output logic [31:0] ifu_r_data_o,
    input  logic        fence_i_i,
    output logic        mem_r_valid_o,
    output logic [31:0] mem_r_addr_o,
    output logic [7:0]  mem_r_len_o,
    input  logic        mem_r_ready_i,
    input  logic [31:0] mem_r_data_i,
    input  logic        mem_r_last_i,
    output logic [31:0] perf_hit_o,
    output logic [31:0] perf_miss_o
);

    localparam int WORDS = 1 << (OFFSET_W - 2);
    localparam int CNT_W = OFFSET_W - 2;
    localparam int TAG_W = 32 - OFFSET_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    icache_state_e          state_q, state_d;
    logic [31:0]            req_addr_q, req_addr_d;
    logic [31:0]            hit_data_q, hit_data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORDS-1:0][31:0] linebuf_q, linebuf_d;
    logic                   full_q, full_d;
    logic                   fence_pend_q, fence_pend_d;
    logic [31:0]            perf_hit_q, perf_hit_d;
    logic [31:0]            perf_miss_q, perf_miss_d;
    logic [WAY_W-1:0]       rr_q [SETS];
    logic [WAY_W-1:0]       rr_d [SETS];

    logic [31:0]            lk_addr;
    logic [INDEX_W-1:0]     lk_index;
    logic [WAYS-1:0]        way_hit, way_valid, way_we;
    logic [WORDS-1:0][31:0] way_line [WAYS];
    logic [WORDS-1:0][31:0] hit_line;
    logic                   inval_all, any_hit, victim_found;
    logic [WAY_W-1:0]       victim;
    logic                   unused_addr_bits;

    // In IDLE the lookup follows the incoming request; otherwise it tracks the
    // held request so RESP sees the valid bits of the set being refilled.
    assign lk_addr   = (state_q == S_IDLE) ? ifu_r_addr_i : req_addr_q;
    assign lk_index  = lk_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign inval_all = (state_q == S_IDLE) && (fence_i_i || fence_pend_q);
    assign any_hit   = (|way_hit) && !inval_all;
    assign unused_addr_bits = ^{ifu_r_addr_i[1:0], req_addr_q[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_we[gi] = (state_q == S_RESP) && full_q && (victim == WAY_W'(gi));
            ysyx_23060077_icache_way #(
                .INDEX_W (INDEX_W),
                .TAG_W   (TAG_W),
                .WORDS   (WORDS)
            ) u_way (
                .clock       (clock),
                .reset       (reset),
                .inval_all_i (inval_all),
                .rd_index_i  (lk_index),
                .rd_tag_i    (lk_addr[31:OFFSET_W+INDEX_W]),
                .hit_o       (way_hit[gi]),
                .valid_o     (way_valid[gi]),
                .rd_line_o   (way_line[gi]),
                .we_i        (way_we[gi]),
                .wr_index_i  (req_addr_q[OFFSET_W+INDEX_W-1:OFFSET_W]),
                .wr_tag_i    (req_addr_q[31:OFFSET_W+INDEX_W]),
                .wr_line_i   (linebuf_q)
            );
        end
    endgenerate

    // Victim: lowest-numbered invalid way, else the set's round-robin pointer.
    always_comb begin
        hit_line     = '0;
        victim       = rr_q[lk_index];
        victim_found = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                hit_line = hit_line | way_line[i];
            end
            if (!way_valid[i]) begin
                victim       = WAY_W'(i);
                victim_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        hit_data_d   = hit_data_q;
        cnt_d        = cnt_q;
        linebuf_d    = linebuf_q;
        full_d       = full_q;
        fence_pend_d = fence_pend_q;
        perf_hit_d   = perf_hit_q;
        perf_miss_d  = perf_miss_q;
        rr_d         = rr_q;
        ifu_r_ready_o = 1'b0;
        ifu_r_data_o  = '0;
        mem_r_valid_o = 1'b0;
        mem_r_addr_o  = '0;
        mem_r_len_o   = '0;
        unique case (state_q)
            S_IDLE: begin
                fence_pend_d = 1'b0;
                if (ifu_r_valid_i) begin
                    req_addr_d = ifu_r_addr_i;
                    if (any_hit) begin
                        state_d    = S_HIT;
                        hit_data_d = hit_line[ifu_r_addr_i[OFFSET_W-1:2]];
                        perf_hit_d = perf_hit_q + 32'd1;
                    end else begin
                        state_d     = S_REFILL;
                        cnt_d       = '0;
                        full_d      = 1'b0;
                        perf_miss_d = perf_miss_q + 32'd1;
                    end
                end
            end
            S_HIT: begin
                ifu_r_ready_o = 1'b1;
                ifu_r_data_o  = hit_data_q;
                state_d       = S_IDLE;
            end
            S_REFILL: begin
                mem_r_valid_o = 1'b1;
                mem_r_addr_o  = {req_addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
                mem_r_len_o   = 8'(WORDS - 1);
                if (mem_r_ready_i) begin
                    linebuf_d[cnt_q] = mem_r_data_i;
                    if (mem_r_last_i) begin
                        // A short burst still answers the fetch but is never installed.
                        full_d  = (cnt_q == CNT_W'(WORDS - 1));
                        cnt_d   = '0;
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RESP: begin
                ifu_r_ready_o = 1'b1;
                ifu_r_data_o  = linebuf_q[req_addr_q[OFFSET_W-1:2]];
                state_d       = S_IDLE;
                if (full_q && !victim_found) begin
                    rr_d[lk_index] = (rr_q[lk_index] == WAY_W'(WAYS - 1)) ? '0
                                   : rr_q[lk_index] + WAY_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && fence_i_i) begin
            fence_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_addr_q   <= '0;
            hit_data_q   <= '0;
            cnt_q        <= '0;
            full_q       <= 1'b0;
            fence_pend_q <= 1'b0;
            perf_hit_q   <= '0;
            perf_miss_q  <= '0;
            for (int i = 0; i < SETS; i++) begin
                rr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            hit_data_q   <= hit_data_d;
            cnt_q        <= cnt_d;
            full_q       <= full_d;
            fence_pend_q <= fence_pend_d;
            perf_hit_q   <= perf_hit_d;
            perf_miss_q  <= perf_miss_d;
            rr_q         <= rr_d;
        end
    end

    always_ff @(posedge clock) begin
        linebuf_q <= linebuf_d;
    end

    assign perf_hit_o  = perf_hit_q;
    assign perf_miss_o = perf_miss_q;

endmodule

// File: doc/ysyx_23060077_icache_assoc.md
YSYX_23060077_ICACHE_ASSOC -- requirements
Module: ysyx_23060077_icache_assoc

Interface
REQ-001 SHALL have parameter OFFSET_W, default 4, giving log2 of line bytes (16 B line, 4 words).
REQ-002 SHALL have parameter INDEX_W, default 4, giving log2 of the set count (16 sets).
REQ-003 SHALL have parameter WAYS, default 2, giving the associativity; legal values are 1, 2, 4.
REQ-004 SHALL have port clock, input, 1 bit: clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have ports ifu_r_valid_i (input, 1), ifu_r_addr_i (input, 32), ifu_r_ready_o (output, 1) and ifu_r_data_o (output, 32), forming the fetch request/response.
REQ-007 SHALL have port fence_i_i, input, 1 bit: invalidate all lines.
REQ-008 SHALL have ports mem_r_valid_o (output, 1), mem_r_addr_o (output, 32), mem_r_len_o (output, 8), mem_r_ready_i (input, 1), mem_r_data_i (input, 32) and mem_r_last_i (input, 1), forming the AXI-style burst read refill port.
REQ-009 SHALL have ports perf_hit_o and perf_miss_o, output, 32 bits each: hit and miss counters.

Function
REQ-010 SHALL split the address into tag [31:OFFSET_W+INDEX_W], index [OFFSET_W+INDEX_W-1:OFFSET_W] and word [OFFSET_W-1:2]; bits [1:0] are ignored.
REQ-011 SHALL implement the states IDLE, HIT, REFILL and RESP.
REQ-012 In IDLE with ifu_r_valid_i=1, SHALL compare all ways of the indexed set, going to HIT on any valid tag match and to REFILL otherwise.
REQ-013 In HIT, SHALL drive ifu_r_ready_o=1 for exactly one cycle with the hit word, then return to IDLE; hit latency is one cycle after acceptance.
REQ-014 In REFILL, SHALL hold mem_r_valid_o=1, mem_r_addr_o = line-aligned address, and mem_r_len_o = 2^(OFFSET_W-2)-1 from entry until the beat carrying mem_r_last_i.
REQ-015 Each beat with mem_r_ready_i=1 SHALL write mem_r_data_i into the line buffer at the beat counter position and increment the counter.
REQ-016 On the last beat, SHALL go to RESP; the counter wraps to 0.
REQ-017 On the RESP edge, SHALL install the line buffer, tag and valid=1 into the victim way.
REQ-018 In RESP, SHALL drive ifu_r_ready_o=1 for one cycle with the requested word from the line buffer, then return to IDLE.
REQ-019 SHALL select the victim as the lowest-numbered invalid way; if none is invalid, SHALL use the per-set round-robin pointer, which then advances modulo WAYS.
REQ-020 An early mem_r_last_i (beat count < 2^(OFFSET_W-2)) SHALL still produce RESP, but the line SHALL NOT be installed.
REQ-021 fence_i_i in IDLE SHALL clear every valid bit in one cycle; a request in that same cycle SHALL be treated as a miss.
REQ-022 fence_i_i in HIT, REFILL or RESP SHALL be latched and applied in the first IDLE cycle, after the in-flight line is installed.
REQ-023 ifu_r_addr_i SHALL be sampled into a request register at acceptance; later changes are ignored until the next IDLE.
REQ-024 perf_hit_o SHALL increment on entry to HIT and perf_miss_o on entry to REFILL; both wrap at 2^32.
REQ-025 Outside their active states, ifu_r_ready_o, mem_r_valid_o, ifu_r_data_o, mem_r_addr_o and mem_r_len_o SHALL be 0.

Reset
REQ-026 reset SHALL force IDLE and clear all valid bits, round-robin pointers, the beat counter, the pending fence flag and the perf counters, with all outputs at 0; tag and data arrays need no reset.
REQ-027 reset mid-REFILL SHALL abandon the burst immediately (mem_r_valid_o=0 next cycle) and install nothing.

Structure
REQ-028 SHALL place the state encodings and the default OFFSET_W, INDEX_W and WAYS constants in the shared ysyx_23060077_define package.
REQ-029 SHALL instantiate one sub-module, ysyx_23060077_icache_way: a tag/valid/data array for one way, with lookup compare and write port, instantiated WAYS times.

Verification
REQ-030 Cold fetch of 0x8000_0004 (defaults): refill from 0x8000_0000 with len=3 and 4 beats; ifu_r_ready_o rises the cycle after the last beat, with beat-1 data; perf_miss_o=1.
REQ-031 Refetch of 0x8000_0008: ifu_r_ready_o one cycle after acceptance, with beat-2 data, no memory traffic, perf_hit_o=1.
REQ-032 Fill 0x8000_0000, 0x8000_0100, 0x8000_0200 (same set, WAYS=2): the third refill evicts way 0; 0x8000_0100 still hits and 0x8000_0000 misses.
REQ-033 fence_i_i asserted mid-refill of 0x8000_0000: the response is delivered, then all lines are invalid, and the next fetch of 0x8000_0000 misses.
REQ-034 reset asserted on beat 2 of a refill: mem_r_valid_o=0 next cycle, counters read 0, and the next fetch misses.
